// File: rtl/hci_package.sv
// Shared HCI definitions: default bus widths, router destination-ID helpers, region record.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package hci_package;

  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_UW = 1;

  // Widest address a region record can hold; narrower buses are zero-extended into it.
  localparam int unsigned MAX_AW = 64;

  // Bits needed to name one real downstream port (at least one bit).
  function automatic int unsigned port_sel_w(input int unsigned nb_port);
    return (nb_port > 1) ? $clog2(nb_port) : 1;
  endfunction

  // Destination IDs cover every real port plus one extra code for the internal error target.
  function automatic int unsigned dest_id_w(input int unsigned nb_port);
    return $clog2(nb_port + 1);
  endfunction

  // The error target is encoded as the first ID past the real ports.
  function automatic int unsigned err_id(input int unsigned nb_port);
    return nb_port;
  endfunction

  // One address region: [start_addr, end_addr) routed to port.
  typedef struct packed {
    logic [MAX_AW-1:0] start_addr;
    logic [MAX_AW-1:0] end_addr;
    logic [7:0]        port;
  } region_map_t;

endpackage

// File: rtl/hci_core_intf.sv
// HCI core request/response bundle between an initiator and a target.
// Latency: none (wires only).
// Backpressure: req/gnt handshake on requests; responses carry no ready.
interface hci_core_intf #(
  parameter int unsigned AW = hci_package::DEFAULT_AW,
  parameter int unsigned DW = hci_package::DEFAULT_DW,
  parameter int unsigned UW = hci_package::DEFAULT_UW
);
  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] be;
  logic [UW-1:0]   user;
  logic [DW-1:0]   r_data;
  logic            r_valid;
  logic            r_opc;
  logic [UW-1:0]   r_user;

  modport master (output req, add, wen, data, be, user,
                  input  gnt, r_data, r_valid, r_opc, r_user);
  modport slave  (input  req, add, wen, data, be, user,
                  output gnt, r_data, r_valid, r_opc, r_user);
endinterface

// File: rtl/hci_core_memmap_rsp_tracker.sv
// In-order FIFO of destination IDs for granted transactions, with occupancy count.
// Latency: a pushed ID becomes the head one cycle later at the earliest (storage is registered).
// Backpressure: pushes are dropped while full, even when a pop happens in the same cycle.
module hci_core_memmap_rsp_tracker #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned IDW   = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           push,
  input  logic [IDW-1:0] push_id,
  input  logic           pop,
  output logic [IDW-1:0] head_id,
  output logic           empty,
  output logic           full,
  output logic [CW-1:0]  count
);
  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDW-1:0]  mem [DEPTH];
  logic [PTRW-1:0] wptr;
  logic [PTRW-1:0] rptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rptr];
  assign count   = cnt;

  // ID storage; contents need no reset because the count qualifies them
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_id;
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/hci_core_memmap_router.sv
// Routes one HCI core slave port to NB_PORT masters by runtime address regions; unmapped hits an internal error target.
// Latency: requests pass combinationally; responses follow the tracker head, at least one cycle after grant.
// Backpressure: grant follows the selected port's gnt, and all requests are held off while MAX_OUTSTANDING are in flight.
module hci_core_memmap_router
  import hci_package::*;
#(
  parameter  int unsigned NB_REGION       = 4,
  parameter  int unsigned NB_PORT         = 2,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  parameter  int unsigned AW              = DEFAULT_AW,
  parameter  int unsigned DW              = DEFAULT_DW,
  parameter  logic [31:0] ERR_DATA        = 32'hbadacce5,
  localparam int unsigned PW              = port_sel_w(NB_PORT),
  localparam int unsigned OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [NB_REGION*AW-1:0] region_start_addr_i,
  input  logic [NB_REGION*AW-1:0] region_end_addr_i,
  input  logic [NB_REGION*PW-1:0] region_port_i,
  hci_core_intf.slave           slave,
  hci_core_intf.master          master [0:NB_PORT-1],
  output logic [OW-1:0]         outstanding_o,
  output logic                  unexpected_rsp_o
);
  localparam int unsigned IDW = dest_id_w(NB_PORT);
  localparam int unsigned NID = 2 ** IDW;
  localparam int unsigned UW  = DEFAULT_UW;
  localparam logic [IDW-1:0] ERR_ID = IDW'(err_id(NB_PORT));

  region_map_t        map [NB_REGION];
  logic [IDW-1:0]     dest;
  logic [IDW-1:0]     head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [NB_PORT-1:0] stray;

  // Per-destination views; IDs past the real ports all behave as the error target
  logic               gnt_v   [NID];
  logic               rvld_v  [NID];
  logic [DW-1:0]      rdata_v [NID];
  logic               ropc_v  [NID];
  logic [UW-1:0]      ruser_v [NID];

  for (genvar r = 0; r < NB_REGION; r++) begin : g_map
    assign map[r] = '{start_addr: MAX_AW'(region_start_addr_i[r*AW +: AW]),
                      end_addr:   MAX_AW'(region_end_addr_i[r*AW +: AW]),
                      port:       8'(region_port_i[r*PW +: PW])};
  end

  // Region decode: scan downward so the lowest-index hit is the one left standing
  always_comb begin
    dest = ERR_ID;
    for (int i = NB_REGION - 1; i >= 0; i--) begin
      if ((MAX_AW'(slave.add) >= map[i].start_addr) && (MAX_AW'(slave.add) < map[i].end_addr))
        dest = (map[i].port < 8'(NB_PORT)) ? IDW'(map[i].port) : ERR_ID;
    end
  end

  for (genvar g = 0; g < NID; g++) begin : g_dst
    if (g < NB_PORT) begin : g_port
      assign master[g].req  = slave.req & (dest == IDW'(g)) & ~full;
      assign master[g].add  = slave.add;
      assign master[g].wen  = slave.wen;
      assign master[g].data = slave.data;
      assign master[g].be   = slave.be;
      assign master[g].user = slave.user;
      assign gnt_v[g]   = master[g].gnt;
      assign rvld_v[g]  = master[g].r_valid;
      assign rdata_v[g] = master[g].r_data;
      assign ropc_v[g]  = master[g].r_opc;
      assign ruser_v[g] = master[g].r_user;
      assign stray[g]   = master[g].r_valid & (empty | (head != IDW'(g)));
    end else begin : g_err
      assign gnt_v[g]   = slave.req;
      assign rvld_v[g]  = 1'b1;
      assign rdata_v[g] = {(DW/32){ERR_DATA}};
      assign ropc_v[g]  = 1'b1;
      assign ruser_v[g] = '0;
    end
  end

  assign slave.gnt = ~full & gnt_v[dest];
  assign push      = slave.req & slave.gnt;
  assign pop       = ~empty & rvld_v[head];

  // Forward the head target's response; an empty tracker keeps the response bus quiet
  always_comb begin
    slave.r_valid = 1'b0;
    slave.r_data  = '0;
    slave.r_opc   = 1'b0;
    slave.r_user  = '0;
    if (!empty) begin
      slave.r_valid = rvld_v[head];
      slave.r_data  = rdata_v[head];
      slave.r_opc   = ropc_v[head];
      slave.r_user  = ruser_v[head];
    end
  end

  hci_core_memmap_rsp_tracker #(
    .DEPTH (MAX_OUTSTANDING),
    .IDW   (IDW)
  ) i_tracker (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .clear   (clear_i),
    .push    (push),
    .push_id (dest),
    .pop     (pop),
    .head_id (head),
    .empty   (empty),
    .full    (full),
    .count   (outstanding_o)
  );

  // Sticky flag for any port answering out of turn; only reset or a flush drops it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       unexpected_rsp_o <= 1'b0;
    else if (clear_i)  unexpected_rsp_o <= 1'b0;
    else if (|stray)   unexpected_rsp_o <= 1'b1;
  end

endmodule

// File: tb/tb_hci_core_memmap_router.sv
// Directed bench for the memory-map router: two modelled targets with programmable latency and a response scoreboard.
// Latency: targets answer lat[p] cycles after their handshake, strictly in order.
// Backpressure: per-target grant can be withheld from the stimulus sequence.
module tb_hci_core_memmap_router;
  import hci_package::*;

  localparam int NR = 4;
  localparam int NP = 2;
  localparam int MO = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] ERRD = 32'hbadacce5;

  typedef struct packed {
    logic [31:0] data;
    logic        opc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic [NR*AW-1:0]  rs;
  logic [NR*AW-1:0]  re;
  logic [NR-1:0]     rp;
  logic [2:0]        outstanding;
  logic              unexp;

  logic              gnt_en [NP];
  int                lat    [NP];
  logic              spur   [NP];

  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  exp_t              sbq [$];
  exp_t              mon_e;
  int                peak;
  int                rv_seen;
  int                first_rv;
  int                g [6];
  int                gd;

  hci_core_intf #(.AW(AW), .DW(DW)) slv ();
  hci_core_intf #(.AW(AW), .DW(DW)) mst [0:NP-1] ();

  hci_core_memmap_router #(
    .NB_REGION(NR), .NB_PORT(NP), .MAX_OUTSTANDING(MO), .AW(AW), .DW(DW), .ERR_DATA(ERRD)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .clear_i             (clear),
    .region_start_addr_i (rs),
    .region_end_addr_i   (re),
    .region_port_i       (rp),
    .slave               (slv),
    .master              (mst),
    .outstanding_o       (outstanding),
    .unexpected_rsp_o    (unexp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] tdata(input int p, input logic [31:0] a);
    return a ^ ((p == 0) ? 32'h1111_0000 : 32'h2222_0000);
  endfunction

  // Target models: capture handshakes at negedge, answer in order once the latency has elapsed
  for (genvar p = 0; p < NP; p++) begin : g_tgt
    logic          rv;
    logic [DW-1:0] rd;
    logic [DW-1:0] qd [$];
    int            qdue [$];
    assign mst[p].gnt     = gnt_en[p];
    assign mst[p].r_valid = rv | spur[p];
    assign mst[p].r_data  = rd;
    assign mst[p].r_opc   = 1'b0;
    assign mst[p].r_user  = '0;
    initial begin
      rv = 1'b0;
      rd = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          qd.delete();
          qdue.delete();
        end else if (mst[p].req && mst[p].gnt) begin
          qd.push_back(tdata(p, mst[p].add));
          qdue.push_back(cyc + lat[p]);
        end
        @(posedge clk);
        #1;
        rv = 1'b0;
        rd = '0;
        if (rst_n && qd.size() > 0 && qdue[0] <= cyc) begin
          rv = 1'b1;
          rd = qd.pop_front();
          qdue.delete(0);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request until granted; queue its expected response
  task automatic send(input logic [31:0] a, input logic [31:0] ed, input logic eo, output int gcyc);
    int n = 0;
    slv.req = 1'b1; slv.add = a; slv.wen = 1'b1; slv.data = a;
    @(negedge clk);
    while (slv.gnt !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("gnt", slv.gnt, 1'b1);
    gcyc = cyc;
    if (slv.gnt === 1'b1) sbq.push_back('{data: ed, opc: eo});
    @(posedge clk);
    #1;
    slv.req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || outstanding != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", outstanding, 0);
    check("drain_scoreboard", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; clear = 1'b0;
    slv.req = 1'b0; slv.add = '0; slv.wen = 1'b1; slv.data = '0; slv.be = '1; slv.user = '0;
    for (int i = 0; i < NP; i++) begin gnt_en[i] = 1'b1; lat[i] = 1; spur[i] = 1'b0; end
    rs = {32'h0, 32'h0, 32'h2000, 32'h1000};
    re = {32'h0, 32'h0, 32'h3000, 32'h2000};
    rp = 4'b0010;
    peak = 0; rv_seen = 0; first_rv = 0;

    // Scoreboard monitor: every slave response must match the oldest expectation
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (int'(outstanding) > peak) peak = int'(outstanding);
          if (slv.r_valid) begin
            if (rv_seen == 0) first_rv = cyc;
            rv_seen++;
            if (sbq.size() == 0) check("rsp_extra", slv.r_valid, 1'b0);
            else begin
              mon_e = sbq.pop_front();
              check("rsp_data", slv.r_data, mon_e.data);
              check("rsp_opc", slv.r_opc, mon_e.opc);
            end
          end
        end
      end
    join_none

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_outstanding", outstanding, 0);
    check("rst_unexpected", unexp, 1'b0);
    check("rst_rvalid", slv.r_valid, 1'b0);
    check("rst_rdata", slv.r_data, 0);
    check("rst_mreq0", mst[0].req, 1'b0);
    check("rst_mreq1", mst[1].req, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back reads to two ports
    peak = 0;
    send(32'h1004, tdata(0, 32'h1004), 1'b0, g[0]);
    send(32'h2008, tdata(1, 32'h2008), 1'b0, g[1]);
    wait_idle();
    check("b2b_gnt_spacing", g[1] - g[0], 1);
    check("b2b_peak_1_or_2", (peak == 1 || peak == 2), 1'b1);

    // Port gnt low holds the slave off while master req stays up
    gnt_en[1] = 1'b0;
    slv.req = 1'b1; slv.add = 32'h2010;
    @(negedge clk);
    check("held_gnt", slv.gnt, 1'b0);
    check("held_mreq1", mst[1].req, 1'b1);
    check("held_mreq0", mst[0].req, 1'b0);
    @(posedge clk);
    #1 gnt_en[1] = 1'b1;
    send(32'h2010, tdata(1, 32'h2010), 1'b0, gd);
    wait_idle();

    // Unmapped address answered by the error target
    slv.req = 1'b1; slv.add = 32'h9000;
    @(negedge clk);
    check("err_gnt", slv.gnt, 1'b1);
    check("err_mreq0", mst[0].req, 1'b0);
    check("err_mreq1", mst[1].req, 1'b0);
    sbq.push_back('{data: ERRD, opc: 1'b1});
    @(posedge clk);
    #1 slv.req = 1'b0;
    @(negedge clk);
    check("err_rvalid", slv.r_valid, 1'b1);
    wait_idle();

    // Tracker full: slow port0, six requests
    lat[0] = 10; peak = 0; rv_seen = 0;
    for (int i = 0; i < 6; i++) send(32'h1000 + 32'(4*i), tdata(0, 32'h1000 + 32'(4*i)), 1'b0, g[i]);
    wait_idle();
    check("full_gnt1", g[1] - g[0], 1);
    check("full_gnt3", g[3] - g[0], 3);
    check("full_gnt4_after_rsp", g[4] - first_rv, 1);
    check("full_gnt5", g[5] - g[4], 1);
    check("full_peak", peak, MO);
    check("full_rsp_count", rv_seen, 6);
    lat[0] = 1;

    // Overlapping regions: lower index wins
    rs[AW +: AW] = 32'h1800;
    slv.req = 1'b1; slv.add = 32'h1800;
    @(negedge clk);
    check("ovl_mreq0", mst[0].req, 1'b1);
    check("ovl_mreq1", mst[1].req, 1'b0);
    sbq.push_back('{data: tdata(0, 32'h1800), opc: 1'b0});
    @(posedge clk);
    #1 slv.req = 1'b0;
    wait_idle();
    rs[AW +: AW] = 32'h2000;

    // Stray response with an empty tracker, then flush
    check("pre_unexpected", unexp, 1'b0);
    spur[1] = 1'b1;
    @(posedge clk);
    #1 spur[1] = 1'b0;
    @(negedge clk);
    check("stray_set", unexp, 1'b1);
    repeat (3) @(negedge clk);
    check("stray_held", unexp, 1'b1);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clear_unexpected", unexp, 1'b0);
    check("clear_outstanding", outstanding, 0);
    @(posedge clk);
    #1;

    // Flush with transactions in flight: late responses become stray
    lat[0] = 5;
    send(32'h1020, tdata(0, 32'h1020), 1'b0, gd);
    send(32'h1024, tdata(0, 32'h1024), 1'b0, gd);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("flush_outstanding", outstanding, 0);
    repeat (8) @(negedge clk);
    check("flush_late_flagged", unexp, 1'b1);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("flush_cleared", unexp, 1'b0);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-burst
    lat[0] = 10;
    for (int i = 0; i < 3; i++) send(32'h1100 + 32'(4*i), tdata(0, 32'h1100 + 32'(4*i)), 1'b0, gd);
    check("burst_outstanding", outstanding, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outstanding", outstanding, 0);
    check("arst_rvalid", slv.r_valid, 1'b0);
    check("arst_unexpected", unexp, 1'b0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lat[0] = 1; rv_seen = 0;
    send(32'h1010, tdata(0, 32'h1010), 1'b0, gd);
    wait_idle();
    check("post_rst_rsp_count", rv_seen, 1);
    check("post_rst_unexpected", unexp, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
